// File: rtl/memory_stage_pkg.sv
// Shared types and helpers for the RV32I memory stage: op encoding, FSM states, lane predicates.
package memory_stage_pkg;

  localparam int unsigned WORD = 32;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT
  } mem_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by off_i and sign/zero extends it.
module load_align_unit
  import memory_stage_pkg::*;
(
  input  logic [WORD-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  mem_op_t         mem_op_i,
  output logic [WORD-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (mem_op_i)
      MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data_o = {24'b0, byte_sel};
      MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: issues loads/stores on a req/ready + rvalid port, passes other ops through,
// and registers the writeback value. mem_busy stalls upstream while an access is outstanding.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            en_i,
  input  logic [WORD-1:0] execute_result_i,
  input  logic [WORD-1:0] store_data_i,
  input  mem_op_t         mem_op_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [WORD-1:0] dmem_addr_o,
  output logic [WORD-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  input  logic [WORD-1:0] dmem_rdata_i,
  output logic [WORD-1:0] mem_result_o,
  output logic            misaligned_o,
  output logic            mem_busy_o
);

  mem_state_t      state_q, state_d;
  mem_op_t         op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic [WORD-1:0] exec_q, exec_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [WORD-1:0] result_q, result_d;
  logic            mis_q, mis_d;

  logic [3:0]      lane_be;
  logic [WORD-1:0] lane_wdata;
  logic [WORD-1:0] load_word;
  logic            new_mis;

  assign new_mis = is_misaligned(mem_op_i, execute_result_i[1:0]);

  // Store lanes are formed from the incoming op so they can be registered at acceptance.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = '0;
    case (mem_op_i)
      MEM_SB: begin
        lane_be    = 4'b0001 << execute_result_i[1:0];
        lane_wdata = {4{store_data_i[7:0]}};
      end
      MEM_SH: begin
        lane_be    = 4'b0011 << execute_result_i[1:0];
        lane_wdata = {2{store_data_i[15:0]}};
      end
      MEM_SW: begin
        lane_be    = 4'b1111;
        lane_wdata = store_data_i;
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = '0;
      end
    endcase
  end

  load_align_unit u_load_align (
    .rdata_i  (dmem_rdata_i),
    .off_i    (off_q),
    .mem_op_i (op_q),
    .data_o   (load_word)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    exec_d   = exec_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    result_d = result_q;
    mis_d    = mis_q;
    case (state_q)
      MEM_IDLE: begin
        if (en_i) begin
          if (mem_op_i == MEM_NONE) begin
            result_d = execute_result_i;
            mis_d    = 1'b0;
          end else if (new_mis) begin
            result_d = '0;
            mis_d    = 1'b1;
          end else begin
            op_d    = mem_op_i;
            off_d   = execute_result_i[1:0];
            exec_d  = execute_result_i;
            req_d   = 1'b1;
            we_d    = is_store(mem_op_i);
            addr_d  = {execute_result_i[WORD-1:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
            mis_d   = 1'b0;
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (dmem_ready_i) begin
          req_d = 1'b0;
          if (is_store(op_q)) begin
            result_d = exec_q;
            state_d  = MEM_IDLE;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          result_d = load_word;
          state_d  = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= MEM_IDLE;
      op_q     <= MEM_NONE;
      off_q    <= '0;
      exec_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      exec_q   <= exec_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      result_q <= result_d;
      mis_q    <= mis_d;
    end
  end

  // Busy drops in the completing cycle so upstream advances on the same edge.
  assign mem_busy_o = ((state_q == MEM_IDLE) && en_i && (mem_op_i != MEM_NONE) && !new_mis)
                    || ((state_q == MEM_REQ) && !(is_store(op_q) && dmem_ready_i))
                    || ((state_q == MEM_WAIT) && !dmem_rvalid_i);

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign mem_result_o = result_q;
  assign misaligned_o = mis_q;

endmodule
